// File: rtl/regfile_16x8_onehot.sv
// Sixteen-entry register bank written through a one-hot enable.
// Supports clear/load/increment/decrement, has two registered read ports, and drives zero/error status flags.
module regfile_16x8_onehot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [15:0]      Enable,
  input  logic [1:0]       FunSel,
  input  logic [WIDTH-1:0] DataIn,
  input  logic [3:0]       OutASel,
  input  logic [3:0]       OutBSel,
  input  logic             ClrErr,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             ZeroFlag,
  output logic             ErrFlag
);

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned SEL_W    = 4;

  localparam logic [1:0] FUN_CLR = 2'b00;
  localparam logic [1:0] FUN_LD  = 2'b01;
  localparam logic [1:0] FUN_INC = 2'b10;
  localparam logic [1:0] FUN_DEC = 2'b11;

  logic [WIDTH-1:0] reg_q [NUM_REGS];
  logic [WIDTH-1:0] reg_d [NUM_REGS];
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic             any_en_c;
  logic             multi_en_c;
  logic             write_c;
  logic [SEL_W-1:0] wr_idx_c;
  logic [WIDTH-1:0] cur_val_c;
  logic [WIDTH-1:0] wr_val_c;

  // Classify the enable: a nonzero value with a second bit set is illegal
  always_comb begin
    any_en_c   = |Enable;
    multi_en_c = |(Enable & (Enable - 16'd1));
    write_c    = any_en_c && !multi_en_c;
  end

  // One-hot to binary index; only meaningful when write_c is set
  always_comb begin
    wr_idx_c = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (Enable[k]) begin
        wr_idx_c = wr_idx_c | SEL_W'(k);
      end
    end
  end

  // Register function applied to the selected entry
  always_comb begin
    cur_val_c = reg_q[wr_idx_c];
    wr_val_c  = cur_val_c;
    case (FunSel)
      FUN_CLR: wr_val_c = '0;
      FUN_LD:  wr_val_c = DataIn;
      FUN_INC: wr_val_c = cur_val_c + WIDTH'(1);
      FUN_DEC: wr_val_c = cur_val_c - WIDTH'(1);
      default: wr_val_c = cur_val_c;
    endcase
  end

  // Next state for storage, read ports and flags
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_d[k] = reg_q[k];
    end
    out_a_d = reg_q[OutASel];
    out_b_d = reg_q[OutBSel];
    zero_d  = zero_q;
    err_d   = err_q;

    if (write_c) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (Enable[k]) begin
          reg_d[k] = wr_val_c;
        end
      end
      zero_d = (wr_val_c == '0);
    end

    // An illegal enable takes priority over a clear request
    if (multi_en_c) begin
      err_d = 1'b1;
    end else if (ClrErr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        reg_q[k] <= '0;
      end
      out_a_q <= '0;
      out_b_q <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        reg_q[k] <= reg_d[k];
      end
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign OutA     = out_a_q;
  assign OutB     = out_b_q;
  assign ZeroFlag = zero_q;
  assign ErrFlag  = err_q;

endmodule

// File: doc/regfile_16x8_onehot.md
# regfile_16x8_onehot

Sixteen-entry general-purpose register bank for the Project 10 datapath. It sits directly downstream of the 4-to-16 write-address decoder and consumes that decoder's one-hot 16-bit enable vector. Each cycle it applies one register function (clear, load, increment or decrement) to the enabled register. It drives two independently addressed, registered read ports plus status flags back to the control unit.

## Interface

Parameters:
- WIDTH, 8, data width of every register and of DataIn/OutA/OutB.

Ports:
- Clock  input  1  rising-edge clock for all state.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Enable  input  16  one-hot write strobe from the address decoder; bit k selects register k; all-zero means no write.
- FunSel  input  2  function applied to the enabled register: 00 clear, 01 load DataIn, 10 increment, 11 decrement.
- DataIn  input  WIDTH  load data, used only when FunSel=01.
- OutASel  input  4  read-port A register index.
- OutBSel  input  4  read-port B register index.
- ClrErr  input  1  synchronous clear of ErrFlag.
- OutA  output  WIDTH  registered read data, port A.
- OutB  output  WIDTH  registered read data, port B.
- ZeroFlag  output  1  registered; 1 if the value written on the last write cycle was zero.
- ErrFlag  output  1  sticky; set when Enable has more than one bit set.

## Operation

- Storage: Reg[0..15], WIDTH bits each, all 0 after Reset.
- Write cycle: Enable has exactly one bit k set. On the rising edge, Reg[k] is updated:
  - FunSel 00: 0.
  - FunSel 01: DataIn.
  - FunSel 10: Reg[k]+1, modulo 2^WIDTH (8'hFF -> 8'h00, no carry out).
  - FunSel 11: Reg[k]-1, modulo 2^WIDTH (8'h00 -> 8'hFF).
- Idle cycle: Enable == 0. No register changes, and ZeroFlag holds its value.
- Illegal cycle: Enable has two or more bits set.
  - No register changes (the whole write is suppressed, not partially applied).
  - ZeroFlag holds.
  - ErrFlag is set to 1.
- ZeroFlag: on a write cycle it is loaded with (new value of Reg[k] == 0).
- ErrFlag:
  - Stays set until Reset, or until a clock edge with ClrErr=1 and no illegal Enable.
  - An illegal Enable in the same cycle as ClrErr=1 wins, and ErrFlag stays 1.
- Read ports:
  - Each clock edge, OutA <= Reg[OutASel] and OutB <= Reg[OutBSel], both using pre-edge register contents.
  - Both ports may select the same register and may equal the write target.
  - There is no write-to-read bypass.

## Timing

- Reset (asynchronous, any time, including mid-write):
  - Reg[0..15] = 0, OutA = 0, OutB = 0, ZeroFlag = 0, ErrFlag = 0 immediately.
  - The first edge after deassertion behaves normally.
- Write latency: 1 edge. The updated Reg[k] is visible on OutA/OutB one edge after it is written, so a read issued in the write cycle returns the old value.
  - Write in cycle n, read select held from cycle n: OutA shows the old value after edge n and the new value after edge n+1.
- Read latency: 1 edge from OutASel/OutBSel change to OutA/OutB.
- ZeroFlag and ErrFlag update on the same edge as the write or illegal cycle that causes them.
- Back-to-back writes to the same register on consecutive cycles are legal. Each increment or decrement uses the value written by the previous edge.
- No handshake and no stall: every cycle is accepted.

## Test plan

- Reset mid-operation:
  - Load 8'hA5 into R3, then assert Reset between edges.
  - Required: OutA, OutB, ZeroFlag and ErrFlag go to 0 without waiting for a clock edge.
  - Required: reading R3 after deassertion returns 8'h00.
- Load, then read on both ports:
  - Enable=16'h0020, FunSel=01, DataIn=8'h3C; OutASel=OutBSel=5 held.
  - Required: OutA=OutB=old value (0) after the write edge, and 8'h3C after the next edge.
- Wrap-around:
  - Load R15=8'hFF, then increment. Required: R15=8'h00 and ZeroFlag=1.
  - Then decrement. Required: R15=8'hFF and ZeroFlag=0.
- Clear and idle:
  - R7=8'h11, then FunSel=00 with Enable=16'h0080. Required: R7=0 and ZeroFlag=1.
  - Then Enable=0 for 3 cycles with FunSel=01, DataIn=8'hAA. Required: all registers unchanged and ZeroFlag still 1.
- Illegal enable:
  - Enable=16'h0003, FunSel=01, DataIn=8'h77, with R0=8'h01 and R1=8'h02 beforehand.
  - Required: R0 and R1 unchanged, and ErrFlag=1 after the edge.
  - Required: ErrFlag stays 1 when ClrErr=1 is applied in the same cycle as a second illegal Enable.
  - Required: ErrFlag clears on the next edge with ClrErr=1 and Enable=16'h0001.
- Full sweep:
  - Load Rk=k*8'h11 for k=0..15 via Enable=1<<k.
  - Then read OutASel=k and OutBSel=15-k. Required: every pair matches one edge later.
